// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions for the HEX display encoder and the
// receive-side decode monitor.
//   SEG_CODE   : active-low g..a pattern for each hex digit 0..F
//   SEG_BLANK  : all segments off
//   ev_t       : payload of one decoded display event
//   seg_encode : hex digit to active-low pattern (used by the encoder)
package seg7_pkg;

  localparam logic [6:0] SEG_CODE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef struct packed {
    logic [3:0] val;
    logic       dot;
    logic       err;
  } ev_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] val);
    return SEG_CODE[val];
  endfunction

endpackage

// File: rtl/seg7_decode_monitor_if.sv
// Decoded-event handshake between the segment monitor (master) and its
// consumer (slave).
//   ev_valid/ev_ready : valid/ready handshake, transfer when both high
//   ev_idx            : display index of the event
//   ev_val/ev_dot     : decoded hex value and dot (1 = lit)
//   ev_err            : pattern was not a legal hex code
interface seg7_decode_monitor_if #(
  parameter int IDX_W = 3
);
  logic             ev_valid;
  logic             ev_ready;
  logic [IDX_W-1:0] ev_idx;
  logic [3:0]       ev_val;
  logic             ev_dot;
  logic             ev_err;

  modport master (output ev_valid, ev_idx, ev_val, ev_dot, ev_err, input ev_ready);
  modport slave  (input ev_valid, ev_idx, ev_val, ev_dot, ev_err, output ev_ready);
endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational seven-segment pattern decoder.
//   pattern : active-low g..a segment pattern
//   val     : matching hex digit, 0 when no legal code matches
//   err     : 1 when the pattern is not one of the 16 legal codes
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] val,
  output logic       err
);

  always_comb begin
    // NOTE: every output gets a default before the search so no latch is inferred.
    val = 4'd0;
    err = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_CODE[i]) begin
        val = i[3:0];
        err = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_decode_monitor.sv
// Receive-side monitor for the multiplexed, active-low HEX segment bus.
// Each display's pattern must be seen STABLE_CYCLES strobes in a row before
// it is accepted; every accepted change is decoded, mirrored into
// hex_word/dot_word and offered as an event on a 1-deep valid/ready slot.
//   clk, rst            : clock, synchronous active-high reset
//   seg_in, dig_sel     : sampled segment bus and display index
//   seg_strobe          : qualifies seg_in/dig_sel
//   ev_if (master)      : decoded-event handshake
//   hex_word, dot_word  : last committed value/dot per display
//   err_sticky          : an illegal pattern was committed since reset
//   ovf_sticky          : an event was dropped since reset
module seg7_decode_monitor
  import seg7_pkg::*;
#(
  parameter  int NUM_DIGITS    = 6,
  parameter  int STABLE_CYCLES = 4,
  localparam int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              seg_in,
  input  logic [IDX_W-1:0]        dig_sel,
  input  logic                    seg_strobe,
  seg7_decode_monitor_if.master   ev_if,
  output logic [4*NUM_DIGITS-1:0] hex_word,
  output logic [NUM_DIGITS-1:0]   dot_word,
  output logic                    err_sticky,
  output logic                    ovf_sticky
);

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);

  logic [7:0]              last_q [NUM_DIGITS];
  logic [7:0]              last_d [NUM_DIGITS];
  logic [7:0]              com_q  [NUM_DIGITS];
  logic [7:0]              com_d  [NUM_DIGITS];
  logic [3:0]              cnt_q  [NUM_DIGITS];
  logic [3:0]              cnt_d  [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   comv_q, comv_d;
  logic                    ev_valid_q, ev_valid_d;
  logic [IDX_W-1:0]        ev_idx_q, ev_idx_d;
  ev_t                     ev_q, ev_d;
  logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [NUM_DIGITS-1:0]   dot_q, dot_d;
  logic                    err_q, err_d, ovf_q, ovf_d;

  logic                    sel_ok, same, commit, drain;
  logic [IDX_W-1:0]        idx;
  logic [3:0]              dec_val;
  logic                    dec_err;

  // Only the committing sample needs decoding, and that is always seg_in.
  seg7_pattern_decode u_dec (
    .pattern (seg_in[6:0]),
    .val     (dec_val),
    .err     (dec_err)
  );

  always_comb begin
    last_d     = last_q;
    com_d      = com_q;
    cnt_d      = cnt_q;
    comv_d     = comv_q;
    ev_valid_d = ev_valid_q;
    ev_idx_d   = ev_idx_q;
    ev_d       = ev_q;
    hex_d      = hex_q;
    dot_d      = dot_q;
    err_d      = err_q;
    ovf_d      = ovf_q;

    sel_ok = seg_strobe && (int'(dig_sel) < NUM_DIGITS);
    // Keep array reads in range when dig_sel points past the last display.
    idx    = sel_ok ? dig_sel : '0;
    same   = (seg_in == last_q[idx]);
    commit = 1'b0;

    if (sel_ok) begin
      if (same) begin
        cnt_d[idx] = (cnt_q[idx] == CNT_MAX) ? CNT_MAX : cnt_q[idx] + 4'd1;
      end else begin
        last_d[idx] = seg_in;
        cnt_d[idx]  = 4'd1;
      end
      // Commit only on the transition into saturation, so a held pattern
      // fires once and a pattern equal to the committed one never re-fires.
      commit = same && (cnt_q[idx] == CNT_MAX - 4'd1) &&
               (!comv_q[idx] || (com_q[idx] != seg_in));
    end

    if (commit) begin
      com_d[idx]              = seg_in;
      comv_d[idx]             = 1'b1;
      hex_d[4*int'(idx) +: 4] = dec_val;
      dot_d[idx]              = ~seg_in[7];
      err_d                   = err_q | dec_err;
    end

    drain = ev_valid_q && ev_if.ev_ready;
    if (drain) ev_valid_d = 1'b0;

    if (commit) begin
      if (!ev_valid_q || drain) begin
        ev_valid_d = 1'b1;
        ev_idx_d   = idx;
        ev_d       = '{val: dec_val, dot: ~seg_in[7], err: dec_err};
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) cnt_q[i] <= 4'd0;
      comv_q     <= '0;
      ev_valid_q <= 1'b0;
      ev_idx_q   <= '0;
      ev_q       <= '0;
      hex_q      <= '0;
      dot_q      <= '0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      cnt_q      <= cnt_d;
      comv_q     <= comv_d;
      ev_valid_q <= ev_valid_d;
      ev_idx_q   <= ev_idx_d;
      ev_q       <= ev_d;
      hex_q      <= hex_d;
      dot_q      <= dot_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
    end
  end

  // NOTE: sample and committed-pattern storage has no reset; zeroed counts
  // and committed-valid bits make stale contents irrelevant.
  always_ff @(posedge clk) begin
    last_q <= last_d;
    com_q  <= com_d;
  end

  assign ev_if.ev_valid = ev_valid_q;
  assign ev_if.ev_idx   = ev_idx_q;
  assign ev_if.ev_val   = ev_q.val;
  assign ev_if.ev_dot   = ev_q.dot;
  assign ev_if.ev_err   = ev_q.err;
  assign hex_word       = hex_q;
  assign dot_word       = dot_q;
  assign err_sticky     = err_q;
  assign ovf_sticky     = ovf_q;

endmodule

// File: tb/tb_seg7_decode_monitor.sv
// Self-checking bench for seg7_decode_monitor: directed scenarios followed by
// randomized traffic, all compared every cycle against a behavioural model
// that tracks unbounded run lengths per display and a 1-entry event slot.
module tb_seg7_decode_monitor;

  localparam int N  = 6;
  localparam int S  = 4;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    seg_in;
  logic [IW-1:0] dig_sel;
  logic          seg_strobe;
  logic [4*N-1:0] hex_word;
  logic [N-1:0]  dot_word;
  logic          err_sticky, ovf_sticky;

  seg7_decode_monitor_if #(.IDX_W(IW)) ev_if ();

  seg7_decode_monitor #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .dig_sel    (dig_sel),
    .seg_strobe (seg_strobe),
    .ev_if      (ev_if),
    .hex_word   (hex_word),
    .dot_word   (dot_word),
    .err_sticky (err_sticky),
    .ovf_sticky (ovf_sticky)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Legal active-low codes for hex digits 0..F, as bytes with bit7 clear.
  logic [6:0] codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state.
  int         run  [N];
  logic [7:0] last [N];
  logic [7:0] com  [N];
  bit         comv [N];
  bit         m_valid;
  int         m_idx;
  logic [3:0] m_val;
  bit         m_dot, m_err, m_errs, m_ovf;
  logic [4*N-1:0] m_hex;
  logic [N-1:0]   m_dotw;

  int hs_count = 0;
  bit dut_v_prev = 1'b0;

  task automatic model_step();
    logic [3:0] v;
    bit e;
    bit drained;
    int d;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        run[i] = 0; comv[i] = 0;
      end
      m_valid = 0; m_idx = 0; m_val = 0; m_dot = 0; m_err = 0;
      m_errs = 0; m_ovf = 0; m_hex = '0; m_dotw = '0;
      return;
    end
    drained = m_valid && ev_if.ev_ready;
    if (drained) m_valid = 0;
    d = int'(dig_sel);
    if (seg_strobe && d < N) begin
      if (run[d] > 0 && seg_in == last[d]) run[d]++;
      else begin
        last[d] = seg_in;
        run[d]  = 1;
      end
      if (run[d] == S && (!comv[d] || com[d] != seg_in)) begin
        v = 4'd0; e = 1;
        for (int k = 0; k < 16; k++)
          if (codes[k] == seg_in[6:0]) begin v = 4'(k); e = 0; end
        com[d] = seg_in; comv[d] = 1;
        m_hex[4*d +: 4] = v;
        m_dotw[d] = ~seg_in[7];
        if (e) m_errs = 1;
        if (m_valid) m_ovf = 1;
        else begin
          m_valid = 1; m_idx = d; m_val = v; m_dot = ~seg_in[7]; m_err = e;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("ev_valid", ev_if.ev_valid, m_valid);
    if (m_valid) begin
      check("ev_idx", ev_if.ev_idx, m_idx);
      check("ev_val", ev_if.ev_val, m_val);
      check("ev_dot", ev_if.ev_dot, m_dot);
      check("ev_err", ev_if.ev_err, m_err);
    end
    check("hex_word", hex_word, m_hex);
    check("dot_word", dot_word, m_dotw);
    check("err_sticky", err_sticky, m_errs);
    check("ovf_sticky", ovf_sticky, m_ovf);
  endtask

  // One clock: count the DUT handshake about to complete, advance the model
  // on the edge, then compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (dut_v_prev && ev_if.ev_ready && !rst) hs_count++;
    model_step();
    @(negedge clk);
    compare_all();
    dut_v_prev = ev_if.ev_valid;
  endtask

  task automatic idle(input int n);
    seg_strobe = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe_n(input int d, input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      dig_sel    = IW'(d);
      seg_in     = s;
      seg_strobe = 1'b1;
      tick();
    end
    seg_strobe = 1'b0;
  endtask

  logic [7:0] pool [4];

  initial begin
    int h0;
    rst = 1'b1; seg_strobe = 1'b0; seg_in = 8'h00; dig_sel = '0;
    ev_if.ev_ready = 1'b0;
    idle(2);
    check("rst_ev_idx", ev_if.ev_idx, 0);
    check("rst_ev_val", ev_if.ev_val, 0);
    check("rst_ev_dot", ev_if.ev_dot, 0);
    check("rst_ev_err", ev_if.ev_err, 0);
    rst = 1'b0;

    // First commit: digit 3 with dot off on display 2.
    strobe_n(2, 8'hB0, 4);
    check("t1_valid", ev_if.ev_valid, 1);
    check("t1_idx", ev_if.ev_idx, 2);
    check("t1_val", ev_if.ev_val, 3);
    check("t1_dot", ev_if.ev_dot, 0);
    check("t1_hex", hex_word[11:8], 3);
    ev_if.ev_ready = 1'b1;
    idle(1);

    // Glitch in the middle of a run restarts the count.
    h0 = hs_count;
    strobe_n(0, 8'h24, 3);
    strobe_n(0, 8'h79, 1);
    strobe_n(0, 8'h24, 4);
    idle(1);
    check("glitch_events", hs_count - h0, 1);
    check("glitch_hex", hex_word[3:0], 2);

    // A held pattern never re-commits; a new one does.
    h0 = hs_count;
    strobe_n(0, 8'h24, 20);
    idle(1);
    check("repeat_events", hs_count - h0, 0);
    strobe_n(0, 8'h19, 4);
    check("dot_val", ev_if.ev_val, 4);
    check("dot_ev", ev_if.ev_dot, 1);
    check("dot_word0", dot_word[0], 1);
    idle(1);

    // Blank is not a legal code.
    strobe_n(5, 8'hFF, 4);
    check("ill_err", ev_if.ev_err, 1);
    check("ill_val", ev_if.ev_val, 0);
    check("ill_sticky", err_sticky, 1);
    check("ill_hex", hex_word[23:20], 0);
    idle(1);

    // Backpressure: second event dropped, words still update.
    ev_if.ev_ready = 1'b0;
    strobe_n(1, 8'h79, 4);
    strobe_n(3, 8'h78, 4);
    check("bp_idx", ev_if.ev_idx, 1);
    check("bp_val", ev_if.ev_val, 1);
    check("bp_ovf", ovf_sticky, 1);
    check("bp_hex", hex_word[15:12], 7);
    strobe_n(4, 8'h99, 3);
    ev_if.ev_ready = 1'b1;
    strobe_n(4, 8'h99, 1);
    check("bp_load_valid", ev_if.ev_valid, 1);
    check("bp_load_idx", ev_if.ev_idx, 4);
    check("bp_load_val", ev_if.ev_val, 4);
    idle(1);

    // Reset mid-run, then re-commit of a previously committed pattern.
    strobe_n(4, 8'h24, 2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("mid_rst_valid", ev_if.ev_valid, 0);
    check("mid_rst_ovf", ovf_sticky, 0);
    strobe_n(4, 8'h99, 4);
    check("recommit_valid", ev_if.ev_valid, 1);
    check("recommit_idx", ev_if.ev_idx, 4);
    idle(1);
    h0 = hs_count;
    strobe_n(7, 8'h30, 6);
    idle(1);
    check("sel7_events", hs_count - h0, 0);

    // Randomized traffic over a small rotating pattern pool.
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        for (int p = 0; p < 4; p++) begin
          if ($urandom_range(0, 7) == 0) pool[p] = 8'($urandom);
          else pool[p] = {1'($urandom_range(0, 1)), codes[$urandom_range(0, 15)]};
        end
      end
      rst            = ($urandom_range(0, 299) == 0);
      seg_strobe     = ($urandom_range(0, 3) != 0);
      dig_sel        = IW'($urandom_range(0, 7));
      seg_in         = pool[$urandom_range(0, 3)];
      ev_if.ev_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
